// File: rtl/lim_dec_countdown.sv
// ---------------------------------------------------------------------------
// lim_dec_countdown
//
// Cascaded modulo-L down-counter for an mm:ss countdown timer. There are four
// 4-bit digits {d3,d2,d1,d0}. A digit that borrows at 0 wraps to its own limit
// Lx. An internal prescaler produces one decrement tick every TICK_DIV clocks
// while running.
//
// Optional feature, selected by the macro COUNTDOWN_AUTORELOAD_EN:
//   When the count reaches 0 on a tick, the last loaded (clamped) value is
//   reloaded on the same edge and the timer keeps running. tc_pulse still
//   fires and done never asserts. If the reload value is 0, the timer stops
//   in DONE as it does without the macro.
//
// Parameters:
//   TICK_DIV  clk cycles per decrement tick (>= 2)
//   L0..L3    per-digit limit, each in 1..15
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   load        1-cycle pulse: load clamped load_val, enter IDLE
//   load_val    {d3,d2,d1,d0} value to load
//   start_stop  1-cycle pulse: start / pause / resume / acknowledge
//   count       current {d3,d2,d1,d0}
//   running     1 while in RUN
//   done        1 while in DONE
//   tc_pulse    1-cycle pulse on the edge where a tick brings count to 0
// ---------------------------------------------------------------------------
module lim_dec_countdown #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter logic [3:0]  L0       = 4'd9,
    parameter logic [3:0]  L1       = 4'd5,
    parameter logic [3:0]  L2       = 4'd9,
    parameter logic [3:0]  L3       = 4'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start_stop,
    output logic [15:0] count,
    output logic        running,
    output logic        done,
    output logic        tc_pulse
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   LIM_V      = {L3, L2, L1, L0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tc_q, tc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [15:0]   reload_q, reload_d;
`endif

    logic [15:0]   clamp_val;
    logic [15:0]   dec_val;
    logic          tick;

    // Per-digit clamp and decrement. A digit sees a borrow-in exactly when
    // every lower digit is zero, so each borrow is computed directly from the
    // lower bits rather than rippled through a chain.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [15:0] LOW_MASK = 16'((32'd1 << (gi * 4)) - 32'd1);
            logic [3:0] lim;
            logic [3:0] dig;
            logic [3:0] ld;
            logic       borrow_in;

            assign lim       = LIM_V[gi*4 +: 4];
            assign dig       = count_q[gi*4 +: 4];
            assign ld        = load_val[gi*4 +: 4];
            assign borrow_in = ((count_q & LOW_MASK) == 16'd0);

            assign clamp_val[gi*4 +: 4] = (ld > lim) ? lim : ld;
            assign dec_val[gi*4 +: 4]   = !borrow_in    ? dig :
                                          (dig == 4'd0) ? lim :
                                                          dig - 4'd1;
        end
    endgenerate

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif

        if (load) begin
            // load takes priority over start_stop in every state
            count_d  = clamp_val;
            presc_d  = '0;
            state_d  = ST_IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_d = clamp_val;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_stop && (count_q != 16'd0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        count_d = dec_val;
                        if (dec_val == 16'd0) begin
                            tc_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (reload_q != 16'd0) begin
                                count_d = reload_q;
                                if (start_stop) begin
                                    state_d = ST_PAUSE;
                                end
                            end else begin
                                state_d = ST_DONE;
                            end
`else
                            // terminal count swallows a coincident start_stop
                            state_d = ST_DONE;
`endif
                        end else if (start_stop) begin
                            state_d = ST_PAUSE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                        if (start_stop) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start_stop) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // status flags are registered copies of the next state
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tc_q      <= tc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign done     = done_q;
    assign tc_pulse = tc_q;

endmodule

// File: tb/tb_lim_dec_countdown.sv
// ---------------------------------------------------------------------------
// tb_lim_dec_countdown
//
// Self-checking bench for lim_dec_countdown with TICK_DIV=4 and default limits.
// A reference model holds the count as a plain integer in mixed radix, holds
// the mode, and counts RUN cycles. It is compared against the DUT on every
// falling edge. Directed scenarios add literal expectations, and a randomized
// phase follows them.
// ---------------------------------------------------------------------------
module tb_lim_dec_countdown;

    localparam int TD     = 4;
    localparam int LIM[4] = '{9, 5, 9, 5};

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        load       = 1'b0;
    logic [15:0] load_val   = 16'h0000;
    logic        start_stop = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        tc_pulse;

    lim_dec_countdown #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .start_stop(start_stop),
        .count     (count),
        .running   (running),
        .done      (done),
        .tc_pulse  (tc_pulse)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int digits_to_val(input logic [15:0] d);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * (LIM[i] + 1) + int'(d[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] val_to_digits(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % (LIM[i] + 1));
            t = t / (LIM[i] + 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp_digits(input logic [15:0] d);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (int'(d[i*4 +: 4]) > LIM[i]) ? 4'(LIM[i]) : d[i*4 +: 4];
        end
        return r;
    endfunction

    int m_mode   = M_IDLE;
    int m_val    = 0;
    int m_phase  = 0;
    int m_reload = 0;
    bit m_tc     = 1'b0;

    always @(posedge clk) begin
        m_tc = 1'b0;
        if (reset) begin
            m_mode   = M_IDLE;
            m_val    = 0;
            m_phase  = 0;
            m_reload = 0;
        end else if (load) begin
            m_val    = digits_to_val(clamp_digits(load_val));
            m_reload = m_val;
            m_phase  = 0;
            m_mode   = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (start_stop && m_val != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (m_phase == TD - 1) begin
                        m_phase = 0;
                        m_val   = m_val - 1;
                        if (m_val == 0) begin
                            m_tc = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (m_reload != 0) m_val = m_reload;
                            else m_mode = M_DONE;
`else
                            m_mode = M_DONE;
`endif
                        end
                        if (m_mode == M_RUN && start_stop) m_mode = M_PAUSE;
                    end else begin
                        m_phase = m_phase + 1;
                        if (start_stop) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (start_stop) m_mode = M_RUN;
                M_DONE:  if (start_stop) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- continuous comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count",    count,            val_to_digits(m_val));
            check("model_running",  16'(running),     16'(m_mode == M_RUN));
            check("model_done",     16'(done),        16'(m_mode == M_DONE));
            check("model_tc_pulse", 16'(tc_pulse),    16'(m_tc));
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic do_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    initial begin
        // 1: reset, then countdown 0102 -> 0059
        reset = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("reset_count",   count,          16'h0000);
        check("reset_running", 16'(running),   16'h0000);
        check("reset_done",    16'(done),      16'h0000);
        check("reset_tc",      16'(tc_pulse),  16'h0000);
        reset = 1'b0;
        cyc(1);

        do_load(16'h0102);
        check("s1_loaded", count, 16'h0102);
        do_ss();
        check("s1_running", 16'(running), 16'h0001);
        check("s1_before_tick", count, 16'h0102);
        cyc(4);
        check("s1_tick1", count, 16'h0101);
        cyc(4);
        check("s1_tick2", count, 16'h0100);
        cyc(4);
        check("s1_tick3_wrap", count, 16'h0059);
        check("s1_still_running", 16'(running), 16'h0001);

`ifndef COUNTDOWN_AUTORELOAD_EN
        // 2: terminal count -> DONE, acknowledge -> IDLE
        do_load(16'h0001);
        do_ss();
        cyc(3);
        check("s2_pre_tc_count", count, 16'h0001);
        check("s2_pre_tc", 16'(tc_pulse), 16'h0000);
        cyc(1);
        check("s2_tc_count",   count,         16'h0000);
        check("s2_tc_done",    16'(done),     16'h0001);
        check("s2_tc_pulse",   16'(tc_pulse), 16'h0001);
        check("s2_tc_running", 16'(running),  16'h0000);
        cyc(1);
        check("s2_tc_one_cycle", 16'(tc_pulse), 16'h0000);
        check("s2_done_held",    16'(done),     16'h0001);
        do_ss();
        check("s2_ack_done", 16'(done),    16'h0000);
        check("s2_ack_idle", 16'(running), 16'h0000);
`else
        // 6: terminal count reloads and keeps running
        do_load(16'h0002);
        do_ss();
        cyc(4);
        check("s6_tick1", count, 16'h0001);
        cyc(4);
        check("s6_reload_count", count,         16'h0002);
        check("s6_reload_tc",    16'(tc_pulse), 16'h0001);
        check("s6_reload_done",  16'(done),     16'h0000);
        check("s6_reload_run",   16'(running),  16'h0001);
        cyc(1);
        check("s6_tc_one_cycle", 16'(tc_pulse), 16'h0000);
`endif

        // 3: clamping, and start with zero count stays IDLE
        do_load(16'hF9F9);
        check("s3_clamp", count, 16'h5959);
        do_load(16'h0000);
        do_ss();
        check("s3_zero_idle", 16'(running), 16'h0000);
        cyc(5);
        check("s3_zero_stays", 16'(running), 16'h0000);

        // 4: pause with prescaler at 2, hold, resume -> tick 2 cycles later
        do_load(16'h1000);
        do_ss();
        cyc(1);
        do_ss();
        check("s4_paused", 16'(running), 16'h0000);
        cyc(20);
        check("s4_held_count", count, 16'h1000);
        check("s4_held_pause", 16'(running), 16'h0000);
        do_ss();
        check("s4_resumed", 16'(running), 16'h0001);
        cyc(1);
        check("s4_no_tick_yet", count, 16'h1000);
        cyc(1);
        check("s4_tick_after_2", count, 16'h0959);

        // 5: reset on the tick cycle, then load + start_stop together
        do_load(16'h0005);
        do_ss();
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("s5_reset_count", count,         16'h0000);
        check("s5_reset_idle",  16'(running),  16'h0000);
        check("s5_reset_no_tc", 16'(tc_pulse), 16'h0000);
        load       = 1'b1;
        start_stop = 1'b1;
        load_val   = 16'h0123;
        cyc(1);
        load       = 1'b0;
        start_stop = 1'b0;
        check("s5_load_wins_count", count,        16'h0123);
        check("s5_load_wins_idle",  16'(running), 16'h0000);
        cyc(6);
        check("s5_idle_holds", count, 16'h0123);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset      = (r == 0);
            load       = (r >= 1 && r <= 6);
            start_stop = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1)
                load_val = 16'($urandom());
            else
                load_val = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            cyc(1);
        end
        reset      = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
